// File: rtl/wavefront_sequencer_if.sv
// Register write/read bus between the AXI register slice and the wavefront sequencer.
//   wready        : write strobe qualifier
//   wr_addr_match : write targets the sequencer
//   wr_sel        : register select (0 CTRL, 1 TIMING, 2 PHASE)
//   wdata         : write data
//   rdata         : sequencer status word
interface wavefront_sequencer_if;
  logic        wready;
  logic        wr_addr_match;
  logic [1:0]  wr_sel;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output wready,
    output wr_addr_match,
    output wr_sel,
    output wdata,
    input  rdata
  );

  modport slave (
    input  wready,
    input  wr_addr_match,
    input  wr_sel,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/wavefront_sequencer.sv
// Run controller for the shorted-cell Ising ring.
// Holds the ring in reset, releases it, injects a programmed number of one-cycle
// wavefront pulses at a fixed period, lets the ring settle and then freezes it
// for readout.
//   clk              : system clock, posedge
//   axi_rstn         : asynchronous active-low reset
//   bus              : register write/read path (CTRL/TIMING/PHASE writes, status read)
//   ising_rstn       : ring enable (0 = hold/freeze, 1 = run)
//   deploy_wavefront : registered one-cycle wavefront pulse
//   busy             : sequence in progress (HOLD, RUN or SETTLE)
//   done             : sequence complete, ring frozen
module wavefront_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  axi_rstn,
  wavefront_sequencer_if.slave  bus,
  output logic                  ising_rstn,
  output logic                  deploy_wavefront,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StHold   = 3'd1;
  localparam logic [2:0] StRun    = 3'd2;
  localparam logic [2:0] StSettle = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;    // shared HOLD / SETTLE cycle counter
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] wave_q, wave_d;
  logic             ising_rstn_q, ising_rstn_d;
  logic             deploy_q, deploy_d;

  logic [CNT_W-1:0] cfg_period_q, cfg_num_q, cfg_settle_q, cfg_hold_q;
  logic [CNT_W-1:0] sh_period_q, sh_num_q, sh_settle_q, sh_hold_q;
  logic [CNT_W-1:0] hold_last, per_last, settle_last;

  logic wr_en, ctrl_wr, start, abort, clear_done, start_ok;

  assign wr_en      = bus.wready & bus.wr_addr_match;
  assign ctrl_wr    = wr_en & (bus.wr_sel == 2'd0);
  assign start      = ctrl_wr & bus.wdata[0];
  assign abort      = ctrl_wr & bus.wdata[1];
  assign clear_done = ctrl_wr & bus.wdata[2];
  assign start_ok   = start & ~abort & ~busy;

  // Terminal counts; a programmed 0 behaves as 1.
  assign hold_last   = (sh_hold_q   == '0) ? '0 : sh_hold_q   - One;
  assign per_last    = (sh_period_q == '0) ? '0 : sh_period_q - One;
  assign settle_last = (sh_settle_q == '0) ? '0 : sh_settle_q - One;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    period_d = period_q;
    wave_d   = wave_q;
    if (abort) begin
      state_d  = StIdle;
      phase_d  = '0;
      period_d = '0;
      wave_d   = '0;
    end else if (start_ok) begin
      state_d  = StHold;
      phase_d  = '0;
      period_d = '0;
      wave_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StHold: begin
          if (phase_q == hold_last) begin
            phase_d = '0;
            state_d = (sh_num_q == '0) ? StSettle : StRun;
          end else begin
            phase_d = phase_q + One;
          end
        end
        StRun: begin
          if (period_q == per_last) begin
            period_d = '0;
            wave_d   = wave_q + One;
            if (wave_d == sh_num_q) state_d = StSettle;
          end else begin
            period_d = period_q + One;
          end
        end
        StSettle: begin
          if (phase_q == settle_last) begin
            phase_d = '0;
            state_d = StDone;
          end else begin
            phase_d = phase_q + One;
          end
        end
        StDone: begin
          if (clear_done) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from next state so the pulse lands in the cycle
  // whose counter value is P-1.
  assign deploy_d     = (state_d == StRun) && (period_d == per_last);
  assign ising_rstn_d = (state_d == StRun) || (state_d == StSettle);

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      period_q     <= '0;
      wave_q       <= '0;
      ising_rstn_q <= 1'b0;
      deploy_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      period_q     <= period_d;
      wave_q       <= wave_d;
      ising_rstn_q <= ising_rstn_d;
      deploy_q     <= deploy_d;
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      cfg_period_q <= '0;
      cfg_num_q    <= '0;
      cfg_settle_q <= '0;
      cfg_hold_q   <= '0;
      sh_period_q  <= '0;
      sh_num_q     <= '0;
      sh_settle_q  <= '0;
      sh_hold_q    <= '0;
    end else begin
      if (wr_en && !busy) begin
        if (bus.wr_sel == 2'd1) begin
          cfg_period_q <= bus.wdata[16 +: CNT_W];
          cfg_num_q    <= bus.wdata[0 +: CNT_W];
        end else if (bus.wr_sel == 2'd2) begin
          cfg_settle_q <= bus.wdata[16 +: CNT_W];
          cfg_hold_q   <= bus.wdata[0 +: CNT_W];
        end
      end
      if (start_ok) begin
        sh_period_q <= cfg_period_q;
        sh_num_q    <= cfg_num_q;
        sh_settle_q <= cfg_settle_q;
        sh_hold_q   <= cfg_hold_q;
      end
    end
  end

  logic [15:0] wave16, period16;
  assign wave16   = 16'(wave_q);
  assign period16 = 16'(period_q);

  assign busy             = (state_q == StHold) || (state_q == StRun) || (state_q == StSettle);
  assign done             = (state_q == StDone);
  assign ising_rstn       = ising_rstn_q;
  assign deploy_wavefront = deploy_q;
  assign bus.rdata        = {state_q, busy, done, 3'b000, wave16[7:0], period16};

endmodule
